// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes and default widths
package axi4_lite_pkg;

   localparam int AXI_ADDR_WIDTH_DEF = 64;
   localparam int AXI_DATA_WIDTH_DEF = 32;
   localparam int BLOCK_WIDTH_DEF    = 512;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_master_read.sv
// rtl/axi4_lite_master_read.sv - cache-block refill master issuing single-beat AXI4-Lite reads
module axi4_lite_master_read
   import axi4_lite_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
   parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
   parameter int BLOCK_WIDTH    = BLOCK_WIDTH_DEF
) (
   input  logic                      clk_i,
   input  logic                      arst_i,
   input  logic                      start_read_i,
   input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
   output logic [BLOCK_WIDTH-1:0]    data_block_o,
   output logic                      read_done_o,
   output logic                      read_error_o,
   output logic                      busy_o,
   output logic                      AR_VALID,
   output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
   output logic [2:0]                AR_PROT,
   input  logic                      AR_READY,
   input  logic                      R_VALID,
   input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
   input  logic [1:0]                R_RESP,
   output logic                      R_READY
);

   localparam int N          = BLOCK_WIDTH / AXI_DATA_WIDTH;
   localparam int KW         = $clog2(N);
   localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
   localparam logic [AXI_ADDR_WIDTH-1:0] BLOCK_MASK = AXI_ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

   state_t                    state_q, state_d;
   logic [KW-1:0]             k_q, k_d;
   logic                      err_q, err_d;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic [BLOCK_WIDTH-1:0]    block_q, block_d;

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         err_q     <= 1'b0;
         ar_addr_q <= '0;
         block_q   <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         err_q     <= err_d;
         ar_addr_q <= ar_addr_d;
         block_q   <= block_d;
      end
   end

   // AR_ADDR is a register that steps by one beat after each accepted R beat,
   // so it is already valid in the cycle ADDR is entered.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      err_d     = err_q;
      ar_addr_d = ar_addr_q;
      block_d   = block_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_read_i) begin
               state_d   = ST_ADDR;
               k_d       = '0;
               err_d     = 1'b0;
               ar_addr_d = addr_i & ~BLOCK_MASK;
            end
         end
         ST_ADDR: begin
            if (AR_READY) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (R_VALID) begin
               block_d[int'(k_q) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = R_DATA;
               err_d = err_q | (R_RESP == AXI_RESP_SLVERR) | (R_RESP == AXI_RESP_DECERR);
               if (k_q == KW'(N - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  k_d       = k_q + KW'(1);
                  ar_addr_d = ar_addr_q + AXI_ADDR_WIDTH'(BEAT_BYTES);
                  state_d   = ST_ADDR;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign AR_VALID     = (state_q == ST_ADDR);
   assign R_READY      = (state_q == ST_DATA);
   assign busy_o       = (state_q != ST_IDLE);
   assign read_done_o  = (state_q == ST_DONE);
   assign read_error_o = (state_q == ST_DONE) & err_q;
   assign AR_ADDR      = ar_addr_q;
   assign AR_PROT      = 3'b000;
   assign data_block_o = block_q;

endmodule

// File: tb/tb_axi4_lite_master_read.sv
// tb/tb_axi4_lite_master_read.sv - scoreboard bench with a behavioural AXI4-Lite slave
module tb_axi4_lite_master_read;
   import axi4_lite_pkg::*;

   localparam int AW = 64;
   localparam int DW = 32;
   localparam int BW = 128;
   localparam int NB = BW / DW;
   localparam int BLK_BYTES = BW / 8;

   logic          clk_i = 1'b0;
   logic          arst_i;
   logic          start_read_i;
   logic [AW-1:0] addr_i;
   logic [BW-1:0] data_block_o;
   logic          read_done_o, read_error_o, busy_o;
   logic          AR_VALID, AR_READY, R_VALID, R_READY;
   logic [AW-1:0] AR_ADDR;
   logic [2:0]    AR_PROT;
   logic [DW-1:0] R_DATA;
   logic [1:0]    R_RESP;

   always #5 clk_i = ~clk_i;

   axi4_lite_master_read #(
      .AXI_ADDR_WIDTH(AW),
      .AXI_DATA_WIDTH(DW),
      .BLOCK_WIDTH   (BW)
   ) dut (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .start_read_i(start_read_i),
      .addr_i      (addr_i),
      .data_block_o(data_block_o),
      .read_done_o (read_done_o),
      .read_error_o(read_error_o),
      .busy_o      (busy_o),
      .AR_VALID    (AR_VALID),
      .AR_ADDR     (AR_ADDR),
      .AR_PROT     (AR_PROT),
      .AR_READY    (AR_READY),
      .R_VALID     (R_VALID),
      .R_DATA      (R_DATA),
      .R_RESP      (R_RESP),
      .R_READY     (R_READY)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard queues filled by the stimulus, drained by the monitor
   logic [AW-1:0] exp_addr_q[$];
   logic [BW-1:0] exp_blk_q[$];
   logic          exp_err_q[$];
   int            exp_lat_q[$];

   // slave memory image, indexed by beat offset inside the block
   logic [DW-1:0] sl_data[NB];
   logic [1:0]    sl_resp[NB];
   int            cfg_arw, cfg_rw;
   bit            cfg_spur;
   bit            sl_pend, ar_hs_s, r_hs_s;
   int            sl_cnt, sl_arw, sl_rw, sl_idx;

   function automatic int pick(input int c);
      return (c >= 0) ? c : int'($urandom_range(0, 3));
   endfunction

   function automatic logic [BW-1:0] model_block();
      logic [BW-1:0] b;
      b = '0;
      for (int i = 0; i < NB; i++) b[i*DW +: DW] = sl_data[i];
      return b;
   endfunction

   initial begin
      AR_READY = 1'b0; R_VALID = 1'b0; R_DATA = '0; R_RESP = '0;
      sl_pend = 1'b0; sl_cnt = 0; sl_idx = 0; sl_arw = 0; sl_rw = 0;
      forever begin
         @(negedge clk_i);
         ar_hs_s = AR_VALID && AR_READY;
         r_hs_s  = R_VALID && R_READY;
         if (ar_hs_s) sl_idx = int'((AR_ADDR % BLK_BYTES) / (DW / 8));
         @(posedge clk_i);
         #1;
         if (arst_i) begin
            sl_pend = 1'b0;
            sl_cnt  = 0;
         end else begin
            if (ar_hs_s) begin sl_pend = 1'b1; sl_cnt = 0; sl_rw = pick(cfg_rw); end
            if (r_hs_s)  begin sl_pend = 1'b0; sl_cnt = 0; sl_arw = pick(cfg_arw); end
         end
         AR_READY = 1'b0; R_VALID = 1'b0; R_DATA = '0; R_RESP = '0;
         if (!arst_i) begin
            if (!sl_pend) begin
               if (AR_VALID) begin
                  if (sl_cnt >= sl_arw) AR_READY = 1'b1;
                  else sl_cnt++;
               end
               if (cfg_spur) begin
                  R_VALID = 1'b1; R_DATA = $urandom; R_RESP = AXI_RESP_DECERR;
               end
            end else begin
               if (sl_cnt >= sl_rw) begin
                  R_VALID = 1'b1; R_DATA = sl_data[sl_idx]; R_RESP = sl_resp[sl_idx];
               end else sl_cnt++;
            end
         end
      end
   end

   int            cyc = 0;
   int            start_cyc = 0;
   bit            ar_hold = 1'b0;
   logic [AW-1:0] ar_a_prev = '0;

   initial begin
      forever begin
         @(negedge clk_i);
         cyc++;
         if (!arst_i) begin
            if (start_read_i && !busy_o) start_cyc = cyc;
            if (ar_hold) begin
               chk("ar_valid_hold", AR_VALID, 1'b1);
               chk("ar_addr_hold", AR_ADDR, ar_a_prev);
            end
            if (AR_VALID && AR_READY) begin
               if (exp_addr_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_ar: got AR_ADDR %0h expected no request", AR_ADDR);
               end else chk("ar_addr", AR_ADDR, exp_addr_q.pop_front());
            end
            if (read_done_o) begin
               if (exp_blk_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got read_done_o 1 expected 0");
               end else begin
                  int lat;
                  chk("done_block", data_block_o, exp_blk_q.pop_front());
                  chk("done_error", read_error_o, exp_err_q.pop_front());
                  lat = exp_lat_q.pop_front();
                  if (lat >= 0) chk("done_latency", cyc - start_cyc, lat);
               end
            end
         end
         ar_hold   = !arst_i && AR_VALID && !AR_READY;
         ar_a_prev = AR_ADDR;
      end
   end

   // caller is at posedge+#1; the slave image must already hold the data for this block
   task automatic launch(input logic [AW-1:0] a, input int arw, input int rw, input bit spur);
      logic [AW-1:0] base;
      logic          err;
      base = a - (a % BLK_BYTES);
      err  = 1'b0;
      for (int i = 0; i < NB; i++) begin
         exp_addr_q.push_back(base + AW'(i * (DW / 8)));
         if (sl_resp[i] >= 2'd2) err = 1'b1;
      end
      exp_blk_q.push_back(model_block());
      exp_err_q.push_back(err);
      exp_lat_q.push_back((arw >= 0 && rw >= 0) ? 1 + NB * (2 + arw + rw) : -1);
      cfg_arw = arw; cfg_rw = rw; cfg_spur = spur;
      sl_arw = pick(arw);
      addr_i = a;
      start_read_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_read_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (n < 300) begin
         @(negedge clk_i);
         if (read_done_o) break;
         n++;
      end
      if (n >= 300) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no read_done_o expected one within 300 cycles", name);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic fill(input bit with_errors);
      for (int i = 0; i < NB; i++) begin
         int r;
         sl_data[i] = $urandom;
         r = int'($urandom_range(0, 7));
         if (!with_errors) sl_resp[i] = AXI_RESP_OKAY;
         else sl_resp[i] = (r == 0) ? AXI_RESP_SLVERR : (r == 1) ? AXI_RESP_DECERR :
                           (r == 2) ? 2'b01 : AXI_RESP_OKAY;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ar_valid"}, AR_VALID, 1'b0);
      chk({tag, "_ar_addr"}, AR_ADDR, '0);
      chk({tag, "_ar_prot"}, AR_PROT, '0);
      chk({tag, "_r_ready"}, R_READY, 1'b0);
      chk({tag, "_block"}, data_block_o, '0);
      chk({tag, "_done"}, read_done_o, 1'b0);
      chk({tag, "_error"}, read_error_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [BW-1:0] held;
      int            n;
      arst_i = 1'b1; start_read_i = 1'b0; addr_i = '0;
      cfg_arw = 0; cfg_rw = 0; cfg_spur = 1'b0;
      for (int i = 0; i < NB; i++) begin sl_data[i] = '0; sl_resp[i] = AXI_RESP_OKAY; end
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_all_zero("reset");
      @(posedge clk_i);
      #1;
      arst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // zero-wait fetch
      for (int i = 0; i < NB; i++) begin sl_data[i] = DW'(32'hA0 + i); sl_resp[i] = AXI_RESP_OKAY; end
      launch(64'h1000, 0, 0, 1'b0);
      wait_done("zero_wait");

      // misaligned address with AR back-pressure
      fill(1'b0);
      launch(64'h2007, 3, 0, 1'b0);
      wait_done("ar_backpressure");

      // SLVERR on beat 2, then a clean fetch
      fill(1'b0);
      sl_resp[2] = AXI_RESP_SLVERR;
      launch(64'h3000, -1, -1, 1'b0);
      wait_done("slverr");
      fill(1'b0);
      launch(64'h3040, 0, 0, 1'b0);
      wait_done("after_err");

      // start pulsed in DATA and in DONE is ignored
      fill(1'b0);
      held = model_block();
      launch(64'h4000, 0, 3, 1'b0);
      n = 0;
      while (!R_READY && n < 50) begin @(negedge clk_i); n++; end
      @(posedge clk_i);
      #1;
      addr_i = 64'h9990;
      start_read_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_read_i = 1'b0;
      n = 0;
      while (n < 300) begin
         @(negedge clk_i);
         if (read_done_o) break;
         n++;
      end
      chk("ignored_done_seen", (n < 300), 1'b1);
      start_read_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_read_i = 1'b0;
      repeat (4) begin
         @(negedge clk_i);
         chk("hold_block", data_block_o, held);
         chk("hold_idle", busy_o, 1'b0);
      end
      @(posedge clk_i);
      #1;

      // reset while beat 1 is in DATA
      fill(1'b0);
      launch(64'h5000, 0, 2, 1'b0);
      n = 0;
      while (!(R_READY && AR_ADDR == 64'h5004) && n < 100) begin @(negedge clk_i); n++; end
      chk("reset_reached_beat1", (n < 100), 1'b1);
      arst_i = 1'b1;
      exp_addr_q.delete(); exp_blk_q.delete(); exp_err_q.delete(); exp_lat_q.delete();
      @(negedge clk_i);
      check_all_zero("midreset");
      arst_i = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         chk("midreset_no_done", read_done_o, 1'b0);
      end
      @(posedge clk_i);
      #1;
      fill(1'b0);
      launch(64'h5000, 0, 0, 1'b0);
      wait_done("after_reset");

      // spurious R_VALID outside DATA carries DECERR and junk data
      fill(1'b0);
      launch(64'h6000, 2, 1, 1'b1);
      wait_done("spurious_r");

      // top of the address space
      fill(1'b1);
      launch(64'hFFFF_FFFF_FFFF_FFF5, -1, -1, 1'b0);
      wait_done("top_addr");

      for (int t = 0; t < 12; t++) begin
         logic [AW-1:0] a;
         a = {$urandom, $urandom};
         fill(1'b1);
         if ($urandom_range(0, 1) == 1)
            launch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         else
            launch(a, -1, -1, 1'($urandom_range(0, 1)));
         wait_done("random");
      end

      cfg_spur = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("leftover_ar", exp_addr_q.size(), 0);
      chk("leftover_done", exp_blk_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
